// File: rtl/seq_det_param_pkg.sv
// seq_det_pkg: shared constants and helpers for the programmable serial
// pattern detector (seq_det_param) and its sub-blocks.
//   DEF_MAX_LEN     - default maximum pattern length
//   LEN_W           - width of a pattern-length field for DEF_MAX_LEN
//   RST_PATTERN_DEF - pattern active after reset (10110101)
//   len_ok()        - legality check for a requested pattern length
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int LEN_W = $clog2(DEF_MAX_LEN + 1);
    localparam logic [7:0] RST_PATTERN_DEF = 8'hB5;

    // A length is usable when at least one bit is compared and the
    // pattern fits in the history register.
    function automatic logic len_ok(input int len, input int max);
        return (len >= 1) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_det_param_if.sv
// seq_det_param_if: serial data, configuration and result signals of the
// pattern detector bundled into one interface.
//   master: drives din/din_valid/cfg_*/cnt_clr, observes match/match_cnt/cfg_err
//   slave : the detector side
interface seq_det_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               din;
    logic               din_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  match, match_cnt, cfg_err
    );

    modport slave (
        input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output match, match_cnt, cfg_err
    );

endinterface

// File: rtl/seq_det_param_satcnt.sv
// seq_det_satcnt: saturating up-counter with synchronous clear.
//   clk - rising-edge clock
//   rst - synchronous active-low reset (count to zero)
//   clr - clear to zero; wins over a simultaneous inc
//   inc - add one unless already all-ones
//   cnt - current count
module seq_det_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// seq_det_param: runtime-programmable serial bit-pattern detector.
// Shifts in one bit per din_valid cycle and pulses match when the newest
// len_q bits equal the low len_q bits of the programmed pattern.
//   clk - rising-edge clock
//   rst - synchronous active-low reset
//   bus - seq_det_param_if slave: din/din_valid stream, cfg_load/cfg_pattern/
//         cfg_len/cfg_overlap configuration, cnt_clr, and registered
//         match/match_cnt/cfg_err outputs
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               MAX_LEN     = 8,
    parameter int               CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(RST_PATTERN_DEF),
    parameter int               RST_LEN     = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_det_param_if.slave bus
);

    localparam int LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill_q, fill_d, fill_n;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;
    logic               hit;

    // Candidate history after shifting in din, and whether that history
    // would complete the active pattern. fill_n saturates at MAX_LEN so the
    // counter never wraps on long streams.
    always_comb begin
        hist_n   = {hist_q[MAX_LEN-2:0], bus.din};
        fill_n   = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
        hit = (fill_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);
    end

    // A load (accepted or not) swallows any din sample of the same cycle.
    // Non-overlapping mode empties the history on a hit so no bit is reused.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;
        if (bus.cfg_load) begin
            if (len_ok(int'(bus.cfg_len), MAX_LEN)) begin
                pat_d  = bus.cfg_pattern;
                len_d  = bus.cfg_len;
                ovl_d  = bus.cfg_overlap;
                fill_d = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (bus.din_valid) begin
            hist_d = hist_n;
            if (hit) begin
                match_d = 1'b1;
                fill_d  = ovl_q ? fill_n : '0;
            end else begin
                fill_d = fill_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= RST_PATTERN;
            len_q     <= LW'(RST_LEN);
            ovl_q     <= 1'b1;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    seq_det_satcnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .inc (match_d),
        .cnt (bus.match_cnt)
    );

    assign bus.match   = match_q;
    assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: directed bench for seq_det_param. Two instances share
// one stimulus stream: one with a 16-bit counter and one with a 2-bit
// counter so saturation shows up naturally. Expected outputs are queued
// as each cycle is driven and compared one clock later.
module tb_seq_det_param;

    typedef struct {
        logic        match;
        logic        err;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t expQ[$];
    logic [15:0] expCnt  = '0;
    logic [1:0]  expCnt2 = '0;

    always #5 clk = ~clk;

    seq_det_param_if #(.MAX_LEN(8), .CNT_W(16)) bus16 ();
    seq_det_param_if #(.MAX_LEN(8), .CNT_W(2))  bus2 ();

    seq_det_param #(
        .MAX_LEN(8), .CNT_W(16), .RST_PATTERN(8'hB5), .RST_LEN(8)
    ) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    seq_det_param #(
        .MAX_LEN(8), .CNT_W(2), .RST_PATTERN(8'hB5), .RST_LEN(8)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = expQ.pop_front();
            total++;
            assert (bus16.match === e.match) else begin
                bad++;
                $error("[TB] FAIL match16 observed=%0b expected=%0b", bus16.match, e.match);
            end
            total++;
            assert (bus2.match === e.match) else begin
                bad++;
                $error("[TB] FAIL match2 observed=%0b expected=%0b", bus2.match, e.match);
            end
            total++;
            assert (bus16.cfg_err === e.err) else begin
                bad++;
                $error("[TB] FAIL cfg_err16 observed=%0b expected=%0b", bus16.cfg_err, e.err);
            end
            total++;
            assert (bus2.cfg_err === e.err) else begin
                bad++;
                $error("[TB] FAIL cfg_err2 observed=%0b expected=%0b", bus2.cfg_err, e.err);
            end
            total++;
            assert (bus16.match_cnt === e.cnt) else begin
                bad++;
                $error("[TB] FAIL match_cnt16 observed=%0d expected=%0d", bus16.match_cnt, e.cnt);
            end
            total++;
            assert (bus2.match_cnt === e.cnt2) else begin
                bad++;
                $error("[TB] FAIL match_cnt2 observed=%0d expected=%0d", bus2.match_cnt, e.cnt2);
            end
        end
    endtask

    // Drive one clock worth of inputs, queue what the outputs must show
    // after that edge, then step the clock and compare.
    task automatic applyStimulus(
        input logic       r,
        input logic       d,
        input logic       dv,
        input logic       ld,
        input logic [7:0] pat,
        input logic [3:0] len,
        input logic       ovl,
        input logic       clr,
        input logic       expMatch,
        input logic       expErr
    );
        exp_t e;
        rst = r;
        bus16.din = d;  bus16.din_valid = dv;  bus16.cfg_load = ld;
        bus16.cfg_pattern = pat;  bus16.cfg_len = len;  bus16.cfg_overlap = ovl;
        bus16.cnt_clr = clr;
        bus2.din = d;   bus2.din_valid = dv;   bus2.cfg_load = ld;
        bus2.cfg_pattern = pat;   bus2.cfg_len = len;   bus2.cfg_overlap = ovl;
        bus2.cnt_clr = clr;
        if (!r || clr) begin
            expCnt  = '0;
            expCnt2 = '0;
        end else if (expMatch) begin
            if (expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
            if (expCnt2 != 2'b11) expCnt2 = expCnt2 + 2'd1;
        end
        e.match = r ? expMatch : 1'b0;
        e.err   = r ? expErr : 1'b0;
        e.cnt   = expCnt;
        e.cnt2  = expCnt2;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic resetCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bubble();
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0,
                      1'b0, 1'b0);
    endtask

    task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input logic expErr, input logic dv, input logic d);
        applyStimulus(1'b1, d, dv, 1'b1, pat, len, ovl, 1'b0, 1'b0, expErr);
    endtask

    // Sends n bits, bits[n-1] first; expMask uses the same bit positions.
    task automatic sendBits(input logic [31:0] bits, input int n, input logic [31:0] expMask,
                            input int maxBubbles);
        for (int k = n - 1; k >= 0; k--) begin
            applyStimulus(1'b1, bits[k], 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, expMask[k], 1'b0);
            if (k > 0) begin
                repeat ($urandom_range(0, maxBubbles)) bubble();
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        resetCycle();
        resetCycle();

        // Reset configuration: 10110101, length 8, overlap on.
        sendBits(32'hB5, 8, 32'h01, 0);

        // Overlapping: two hits in 1011010110101.
        loadCfg(8'hB5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        sendBits(32'b1011010110101, 13, 32'h21, 0);

        // Non-overlapping: only the first hit survives.
        loadCfg(8'hB5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        sendBits(32'b1011010110101, 13, 32'h20, 0);

        // Length 3, pattern 101; upper pattern bits must be ignored.
        loadCfg(8'hF5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        sendBits(32'b10101, 5, 32'b00100, 0);
        loadCfg(8'hF5, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        sendBits(32'b10101, 5, 32'b00101, 0);

        // Rejected loads keep configuration and history; a load with
        // din_valid drops that bit.
        loadCfg(8'hB5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        loadCfg(8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        sendBits(32'b1011010, 7, 32'h0, 0);
        loadCfg(8'hFF, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1);
        sendBits(32'b1, 1, 32'b1, 0);

        // Bubbles inside the pattern do not break it.
        loadCfg(8'hB5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        sendBits(32'hB5, 8, 32'h01, 3);

        // Reset mid-pattern discards history.
        sendBits(32'b1011010, 7, 32'h0, 0);
        resetCycle();
        sendBits(32'b1, 1, 32'h0, 0);
        sendBits(32'hB5, 8, 32'h01, 0);

        // Clear on a match cycle: match pulses, count goes to zero.
        loadCfg(8'hB5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        sendBits(32'b1011010, 7, 32'h0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Length-1 pattern: back-to-back hits, 2-bit counter saturates.
        loadCfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        sendBits(32'b11110, 5, 32'b11110, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
